// File: rtl/cmp_rr_arbiter.sv
// ============================================================================
// cmp_rr_arbiter : round-robin arbiter sharing one 8-bit magnitude comparator
// Revision       : 1.0
// ============================================================================
`default_nettype none

module comparator_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       less,
  output logic       equal,
  output logic       great
);

  assign less  = (a <  b);
  assign equal = (a == b);
  assign great = (a >  b);

endmodule

module cmp_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] a_bus,
  input  logic [8*NREQ-1:0] b_bus,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic              rsp_less,
  output logic              rsp_equal,
  output logic              rsp_great
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMP  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]      r_state;
  logic [ID_W-1:0] r_last;
  logic [7:0]      r_op_a;
  logic [7:0]      r_op_b;
  logic            r_valid;
  logic [ID_W-1:0] r_id;
  logic            r_less;
  logic            r_equal;
  logic            r_great;

  logic [NREQ-1:0] w_gnt;
  logic [ID_W-1:0] w_gnt_idx;
  logic            w_found;
  logic            w_less;
  logic            w_equal;
  logic            w_great;

  // Two passes: indices above the last winner first, then wrap to the rest.
  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_found   = 1'b0;
    if (r_state == IDLE) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_found && req[i] && (ID_W'(i) > r_last)) begin
          w_gnt[i]  = 1'b1;
          w_gnt_idx = ID_W'(i);
          w_found   = 1'b1;
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!w_found && req[i] && (ID_W'(i) <= r_last)) begin
          w_gnt[i]  = 1'b1;
          w_gnt_idx = ID_W'(i);
          w_found   = 1'b1;
        end
      end
    end
  end

  comparator_8bit u_cmp (
    .a     (r_op_a),
    .b     (r_op_b),
    .less  (w_less),
    .equal (w_equal),
    .great (w_great)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= ID_W'(NREQ - 1);
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_less  <= 1'b0;
      r_equal <= 1'b0;
      r_great <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_op_a  <= a_bus[8*w_gnt_idx +: 8];
            r_op_b  <= b_bus[8*w_gnt_idx +: 8];
            r_id    <= w_gnt_idx;
            r_last  <= w_gnt_idx;
            r_state <= CMP;
          end
        end
        CMP: begin
          r_less  <= w_less;
          r_equal <= w_equal;
          r_great <= w_great;
          r_valid <= 1'b1;
          r_state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_valid <= 1'b0;
            r_less  <= 1'b0;
            r_equal <= 1'b0;
            r_great <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Gate with rst_n so the combinational grant also drops the moment reset asserts.
  assign gnt       = rst_n ? w_gnt : '0;
  assign busy      = (r_state != IDLE);
  assign rsp_valid = r_valid;
  assign rsp_id    = r_id;
  assign rsp_less  = r_less;
  assign rsp_equal = r_equal;
  assign rsp_great = r_great;

endmodule

`default_nettype wire

// File: tb/tb_cmp_rr_arbiter.sv
// ============================================================================
// tb_cmp_rr_arbiter : directed self-checking bench for cmp_rr_arbiter
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_cmp_rr_arbiter;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] a_bus;
  logic [8*NREQ-1:0] b_bus;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic              rsp_less;
  logic              rsp_equal;
  logic              rsp_great;

  int total = 0;
  int bad   = 0;
  logic watch3 = 1'b0;
  logic seen3  = 1'b0;

  cmp_rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_bus     (a_bus),
    .b_bus     (b_bus),
    .gnt       (gnt),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_less  (rsp_less),
    .rsp_equal (rsp_equal),
    .rsp_great (rsp_great)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk) begin
    if (watch3 && ((gnt[3] === 1'b1) || (rsp_valid === 1'b1 && rsp_id === 2'd3)))
      seen3 <= 1'b1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] flags();
    return {rsp_less, rsp_equal, rsp_great};
  endfunction

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    a_bus[8*i +: 8] = a;
    b_bus[8*i +: 8] = b;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"}, 16'(gnt), 16'h0);
    check({tag, "_busy"}, 16'(busy), 16'h0);
    check({tag, "_valid"}, 16'(rsp_valid), 16'h0);
    check({tag, "_id"}, 16'(rsp_id), 16'h0);
    check({tag, "_flags"}, 16'(flags()), 16'h0);
  endtask

  logic [1:0] exp_id [5];
  logic [2:0] exp_fl [5];

  initial begin
    rst_n = 1'b0; req = '0; a_bus = '0; b_bus = '0; rsp_ready = 1'b0;
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_fl = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b100};

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    check_idle_outputs("reset");
    @(negedge clk); rst_n = 1'b1;

    // Single equal compare on requester 0
    @(negedge clk);
    req = 4'b0001; set_ops(0, 8'h35, 8'h35); rsp_ready = 1'b1; #1;
    check("t1_gnt_c0", 16'(gnt), 16'h1);
    @(negedge clk); req = 4'b0000; #1;
    check("t1_busy_c1", 16'(busy), 16'h1);
    check("t1_valid_c1", 16'(rsp_valid), 16'h0);
    @(negedge clk); #1;
    check("t1_valid_c2", 16'(rsp_valid), 16'h1);
    check("t1_id_c2", 16'(rsp_id), 16'h0);
    check("t1_flags_c2", 16'(flags()), 16'b010);
    @(negedge clk); #1;
    check("t1_busy_c3", 16'(busy), 16'h0);
    check("t1_valid_c3", 16'(rsp_valid), 16'h0);

    // Reset pointer, then fairness rotation with all four held
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    set_ops(0, 8'h10, 8'h20); set_ops(1, 8'h80, 8'h7F);
    set_ops(2, 8'hFF, 8'hFF); set_ops(3, 8'h00, 8'h01);
    req = 4'b1111; #1;
    for (int g = 0; g < 5; g++) begin
      check($sformatf("t2_gnt_%0d", g), 16'(gnt), 16'(4'b0001 << exp_id[g]));
      @(negedge clk); #1;
      check($sformatf("t2_gnt0_c1_%0d", g), 16'(gnt), 16'h0);
      @(negedge clk); #1;
      check($sformatf("t2_valid_%0d", g), 16'(rsp_valid), 16'h1);
      check($sformatf("t2_id_%0d", g), 16'(rsp_id), 16'(exp_id[g]));
      check($sformatf("t2_flags_%0d", g), 16'(flags()), 16'(exp_fl[g]));
      @(negedge clk);
      if (g == 4) req = 4'b0000;
      #1;
    end
    check("t2_quiet_gnt", 16'(gnt), 16'h0);

    // Backpressure on requester 2, requester 1 waiting (pointer is now 0)
    @(negedge clk);
    rsp_ready = 1'b0; req = 4'b0100; set_ops(2, 8'hA0, 8'h0A); #1;
    check("t3_gnt_c0", 16'(gnt), 16'h4);
    @(negedge clk); req = 4'b0010; set_ops(1, 8'h01, 8'h02); #1;
    check("t3_gnt_c1", 16'(gnt), 16'h0);
    @(negedge clk); #1;
    check("t3_valid_c2", 16'(rsp_valid), 16'h1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      check($sformatf("t3_hold_valid_%0d", k), 16'(rsp_valid), 16'h1);
      check($sformatf("t3_hold_id_%0d", k), 16'(rsp_id), 16'h2);
      check($sformatf("t3_hold_flags_%0d", k), 16'(flags()), 16'b001);
      check($sformatf("t3_hold_gnt_%0d", k), 16'(gnt), 16'h0);
    end
    @(negedge clk); rsp_ready = 1'b1; #1;
    check("t3_ready_valid", 16'(rsp_valid), 16'h1);

    // Requester 1 granted next; its operand changes after the grant edge
    @(negedge clk); #1;
    check("t4_gnt_c0", 16'(gnt), 16'h2);
    @(negedge clk); req = 4'b0000; a_bus[15:8] = 8'hFF; #1;
    check("t4_busy_c1", 16'(busy), 16'h1);
    @(negedge clk); #1;
    check("t4_id_c2", 16'(rsp_id), 16'h1);
    check("t4_flags_c2", 16'(flags()), 16'b100);
    @(negedge clk); #1;
    check("t4_busy_c3", 16'(busy), 16'h0);

    // Async reset during CMP; pointer (now 0) must return to NREQ-1
    @(negedge clk); req = 4'b0001; set_ops(0, 8'h05, 8'h03); #1;
    check("t5_gnt_c0", 16'(gnt), 16'h1);
    @(negedge clk); req = 4'b1001; set_ops(3, 8'h09, 8'h09);
    #2 rst_n = 1'b0; #1;
    check_idle_outputs("t5_async");
    @(negedge clk); #1;
    check("t5_in_reset_valid", 16'(rsp_valid), 16'h0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("t5_gnt_after", 16'(gnt), 16'h1);
    @(negedge clk); req = 4'b0000; #1;
    @(negedge clk); #1;
    check("t5_id", 16'(rsp_id), 16'h0);
    check("t5_flags", 16'(flags()), 16'b001);
    @(negedge clk); #1;

    // Requester 3 drops its request while requester 1 holds the grant
    @(negedge clk); watch3 = 1'b1; req = 4'b0010; set_ops(1, 8'h07, 8'h09); #1;
    check("t6_gnt_c0", 16'(gnt), 16'h2);
    @(negedge clk); req = 4'b1000; #1;
    check("t6_gnt_c1", 16'(gnt), 16'h0);
    @(negedge clk); req = 4'b0000; #1;
    check("t6_id_c2", 16'(rsp_id), 16'h1);
    check("t6_flags_c2", 16'(flags()), 16'b100);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      check($sformatf("t6_idle_gnt_%0d", k), 16'(gnt), 16'h0);
    end
    watch3 = 1'b0;
    check("t6_never_id3", 16'(seen3), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
